// File: rtl/uio_bus_arbiter_if.sv
// Shared uio pad bus between the two internal requesters and the pad-side sequencer.
// The arbiter takes the slave modport; requesters/pads sit on the master side.
interface uio_bus_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREQ   = 2;

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   dir;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] uio_in;
    logic [NREQ-1:0]   gnt;
    logic [DATA_W-1:0] rdata;
    logic [NREQ-1:0]   rvalid;
    logic [DATA_W-1:0] uio_out;
    logic [DATA_W-1:0] uio_oe;
    logic              busy;

    modport master (
        output req, dir, wdata0, wdata1, uio_in,
        input  gnt, rdata, rvalid, uio_out, uio_oe, busy
    );

    modport slave (
        input  req, dir, wdata0, wdata1, uio_in,
        output gnt, rdata, rvalid, uio_out, uio_oe, busy
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8-bit uio pad bus with tri-state turnaround and hold limit.
// Writes drive the pads from the owner's wdata; reads capture uio_in into rdata.
module uio_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     ena,
    uio_bus_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREQ   = 2;
    localparam int unsigned TURN_W = 4;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              owner, owner_nx;
    logic              own_dir, own_dir_nx;
    logic              last, last_nx;
    logic [TURN_W-1:0] turn_cnt, turn_cnt_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;

    logic              clear;
    logic              idle_pick;
    logic              peer;
    logic              forced;
    logic              release_own;

    logic [NREQ-1:0]   gnt_q, gnt_nx;
    logic [NREQ-1:0]   rvalid_q, rvalid_nx;
    logic [DATA_W-1:0] rdata_q, rdata_nx;
    logic [DATA_W-1:0] uio_out_c, uio_oe_c;
    logic              busy_c;

    assign clear       = !rst_n || !ena;
    assign idle_pick   = (bus.req == 2'b11) ? ~last : bus.req[1];
    assign peer        = ~owner;
    assign forced      = (hold_cnt == HOLD_W'(MAX_HOLD)) && bus.req[peer];
    assign release_own = !bus.req[owner] || forced;

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            owner    <= 1'b0;
            own_dir  <= 1'b0;
            last     <= 1'b1;
            turn_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            own_dir  <= own_dir_nx;
            last     <= last_nx;
            turn_cnt <= turn_cnt_nx;
            hold_cnt <= hold_cnt_nx;
        end
    end

    // Next state; the winner and its direction are latched only when leaving IDLE or OWN
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        own_dir_nx  = own_dir;
        last_nx     = last;
        turn_cnt_nx = turn_cnt;
        hold_cnt_nx = hold_cnt;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_nx    = TURN;
                    owner_nx    = idle_pick;
                    own_dir_nx  = bus.dir[idle_pick];
                    last_nx     = idle_pick;
                    turn_cnt_nx = '0;
                end
            end
            TURN: begin
                if (turn_cnt == TURN_W'(TURN_CYCLES - 1)) begin
                    state_nx    = OWN;
                    hold_cnt_nx = HOLD_W'(1);
                end else begin
                    turn_cnt_nx = turn_cnt + TURN_W'(1);
                end
            end
            OWN: begin
                if (release_own) begin
                    hold_cnt_nx = '0;
                    if (bus.req[peer]) begin
                        state_nx    = TURN;
                        owner_nx    = peer;
                        own_dir_nx  = bus.dir[peer];
                        last_nx     = peer;
                        turn_cnt_nx = '0;
                    end else begin
                        state_nx    = IDLE;
                    end
                end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                    hold_cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output decode: next values for registered outputs, pad drive from registered owner/dir
    always_comb begin
        gnt_nx    = '0;
        rvalid_nx = '0;
        rdata_nx  = rdata_q;
        uio_out_c = '0;
        uio_oe_c  = '0;
        busy_c    = (state != IDLE);
        if (state_nx == OWN) begin
            gnt_nx = owner_nx ? 2'b10 : 2'b01;
        end
        if (state == OWN) begin
            if (own_dir) begin
                uio_oe_c  = 8'hFF;
                uio_out_c = owner ? bus.wdata1 : bus.wdata0;
            end else begin
                rdata_nx  = bus.uio_in;
                rvalid_nx = owner ? 2'b10 : 2'b01;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (clear) begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            gnt_q    <= gnt_nx;
            rvalid_q <= rvalid_nx;
            rdata_q  <= rdata_nx;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.uio_out = uio_out_c;
    assign bus.uio_oe  = uio_oe_c;
    assign bus.busy    = busy_c;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Cycle-vector bench for uio_bus_arbiter (TURN_CYCLES=1, MAX_HOLD=4): each vector's
// expected outputs are queued when its inputs are driven and checked after the edge.
module tb_uio_bus_arbiter;
    typedef struct {
        logic       rst_n;
        logic       ena;
        logic [1:0] req;
        logic [1:0] dir;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] uin;
        logic [1:0] gnt;
        logic [7:0] oe;
        logic [7:0] uout;
        logic [1:0] rv;
        logic [7:0] rd;
        logic       busy;
    } vec_t;

    logic clk;
    logic rst_n;
    logic ena;
    int   n_checks;
    int   n_fail;
    int   vec_idx;
    vec_t vecs[$];
    vec_t exp_q[$];

    uio_bus_if bus();

    uio_bus_arbiter #(
        .TURN_CYCLES(1),
        .MAX_HOLD   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst_n_i, input logic ena_i, input logic [1:0] req_i, input logic [1:0] dir_i,
        input logic [7:0] w0_i, input logic [7:0] w1_i, input logic [7:0] uin_i,
        input logic [1:0] gnt_i, input logic [7:0] oe_i, input logic [7:0] uout_i,
        input logic [1:0] rv_i, input logic [7:0] rd_i, input logic busy_i);
        vec_t v;
        v.rst_n = rst_n_i; v.ena = ena_i; v.req = req_i; v.dir = dir_i;
        v.w0 = w0_i; v.w1 = w1_i; v.uin = uin_i;
        v.gnt = gnt_i; v.oe = oe_i; v.uout = uout_i; v.rv = rv_i; v.rd = rd_i; v.busy = busy_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, vec_idx, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n      = v.rst_n;
        ena        = v.ena;
        bus.req    = v.req;
        bus.dir    = v.dir;
        bus.wdata0 = v.w0;
        bus.wdata1 = v.w1;
        bus.uio_in = v.uin;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("gnt",     8'(bus.gnt),    8'(e.gnt));
        chk("uio_oe",  bus.uio_oe,     e.oe);
        chk("uio_out", bus.uio_out,    e.uout);
        chk("rvalid",  8'(bus.rvalid), 8'(e.rv));
        chk("rdata",   bus.rdata,      e.rd);
        chk("busy",    8'(bus.busy),   8'(e.busy));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        vec_idx    = 0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        bus.req    = '0;
        bus.dir    = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        bus.uio_in = '0;

        //                rst  ena  req    dir    w0     w1     uin   | gnt    oe     uout   rv     rd     busy
        // Reset, then requester 0 writes
        vecs.push_back(mk(1'b0,1'b1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,2'b01,2'b01,8'hA5,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b0));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'hA5,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'hA5,8'h00,8'h00, 2'b01,8'hFF,8'hA5,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'h3C,8'h00,8'h00, 2'b01,8'hFF,8'h3C,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b00,2'b01,8'h3C,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b0));
        // Requester 1 reads a stepping pad value
        vecs.push_back(mk(1'b1,1'b1,2'b10,2'b00,8'h00,8'h99,8'h0F, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b10,2'b00,8'h00,8'h99,8'h0F, 2'b10,8'h00,8'h00,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b10,2'b00,8'h00,8'h99,8'h10, 2'b10,8'h00,8'h00,2'b10,8'h10,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b10,2'b00,8'h00,8'h99,8'h11, 2'b10,8'h00,8'h00,2'b10,8'h11,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b10,2'b00,8'h00,8'h99,8'h12, 2'b10,8'h00,8'h00,2'b10,8'h12,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b00,2'b00,8'h00,8'h99,8'h13, 2'b00,8'h00,8'h00,2'b10,8'h13,1'b0));
        vecs.push_back(mk(1'b1,1'b1,2'b00,2'b00,8'h00,8'h99,8'h14, 2'b00,8'h00,8'h00,2'b00,8'h13,1'b0));
        // Tie from reset, round-robin hand-over, next tie back to requester 0
        vecs.push_back(mk(1'b0,1'b1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b0));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b00,8'h00,8'h00,8'h20, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b00,8'h00,8'h00,8'h20, 2'b01,8'h00,8'h00,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b00,8'h00,8'h00,8'h21, 2'b01,8'h00,8'h00,2'b01,8'h21,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b10,2'b00,8'h00,8'h00,8'h22, 2'b00,8'h00,8'h00,2'b01,8'h22,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b10,2'b00,8'h00,8'h00,8'h23, 2'b10,8'h00,8'h00,2'b00,8'h22,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b00,2'b00,8'h00,8'h00,8'h24, 2'b00,8'h00,8'h00,2'b10,8'h24,1'b0));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h24,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b00,8'h00,8'h00,8'h00, 2'b01,8'h00,8'h00,2'b00,8'h24,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b00,2'b00,8'h00,8'h00,8'h25, 2'b00,8'h00,8'h00,2'b01,8'h25,1'b0));
        // Forced release after four OWN cycles once requester 1 waits
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'h5A,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h25,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'h5A,8'h00,8'h00, 2'b01,8'hFF,8'h5A,2'b00,8'h25,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b01,8'h5A,8'h00,8'h00, 2'b01,8'hFF,8'h5A,2'b00,8'h25,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b01,8'h5A,8'h00,8'h00, 2'b01,8'hFF,8'h5A,2'b00,8'h25,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b01,8'h5A,8'h00,8'h00, 2'b01,8'hFF,8'h5A,2'b00,8'h25,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b01,8'h5A,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h25,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b01,8'h5A,8'h00,8'h00, 2'b10,8'h00,8'h00,2'b00,8'h25,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b11,2'b01,8'h5A,8'h00,8'h30, 2'b10,8'h00,8'h00,2'b10,8'h30,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'h5A,8'h00,8'h31, 2'b00,8'h00,8'h00,2'b10,8'h31,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'h5A,8'h00,8'h00, 2'b01,8'hFF,8'h5A,2'b00,8'h31,1'b1));
        // Lone owner keeps the bus past MAX_HOLD; dir toggles are ignored while owning
        for (int i = 0; i < 60; i++) begin
            vecs.push_back(mk(1'b1,1'b1,2'b01,2'({1'b0, i[0]}),8'(i + 64),8'h00,8'h00,
                              2'b01,8'hFF,8'(i + 64),2'b00,8'h31,1'b1));
        end
        vecs.push_back(mk(1'b1,1'b1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h31,1'b0));
        // Re-grant picks up the new (read) direction
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b00,8'hEE,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h31,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'hEE,8'h00,8'h00, 2'b01,8'h00,8'h00,2'b00,8'h31,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'hEE,8'h00,8'h77, 2'b01,8'h00,8'h00,2'b01,8'h77,1'b1));
        // ena low during read-OWN, then rst_n low during write-OWN
        vecs.push_back(mk(1'b1,1'b0,2'b01,2'b01,8'hEE,8'h00,8'h88, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b0));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'hC3,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b1,1'b1,2'b01,2'b01,8'hC3,8'h00,8'h00, 2'b01,8'hFF,8'hC3,2'b00,8'h00,1'b1));
        vecs.push_back(mk(1'b0,1'b1,2'b01,2'b01,8'hC3,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b0));
        vecs.push_back(mk(1'b1,1'b1,2'b00,2'b00,8'hC3,8'h00,8'h00, 2'b00,8'h00,8'h00,2'b00,8'h00,1'b0));

        foreach (vecs[i]) begin
            vec_idx = i;
            apply(vecs[i]);
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
